// File: rtl/slant_pkg.sv
// rtl/slant_pkg.sv - shared constants and types for the slant read-port arbiter
// Purpose: slot phase encodings, requester tags and the slot-ownership lookup
//          used by slant_slot_wheel and slant_rdport_arbiter.
// Ports:   none (package).
package slant_pkg;

  localparam logic [2:0] PH_HDMI0 = 3'd0;
  localparam logic [2:0] PH_HDMI1 = 3'd1;
  localparam logic [2:0] PH_TX0   = 3'd2;
  localparam logic [2:0] PH_TX1   = 3'd3;
  localparam logic [2:0] PH_DBG   = 3'd4;
  localparam logic [2:0] PH_LAST  = 3'd4;

  // Tag carried alongside each read so the return stage knows who issued it.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_HDMI = 2'd1,
    TAG_TX   = 2'd2,
    TAG_DBG  = 2'd3
  } tag_t;

  localparam int REQ_HDMI = 0;
  localparam int REQ_TX   = 1;
  localparam int REQ_DBG  = 2;
  localparam int NUM_REQ  = 3;

  // Owner of the slot at a given wheel phase.
  function automatic tag_t slot_owner(input logic [2:0] ph);
    tag_t own;
    case (ph)
      PH_HDMI0, PH_HDMI1: own = TAG_HDMI;
      PH_TX0, PH_TX1:     own = TAG_TX;
      PH_DBG:             own = TAG_DBG;
      default:            own = TAG_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/slant_slot_wheel.sv
// rtl/slant_slot_wheel.sv - 5-phase slot wheel and divided pixel clock
// Purpose: counts phase 0..4 every Cclk, restarts at 0 on phase_align and
//          produces a registered pix_clk that is high during phases 0 and 1.
// Ports:
//   Cclk        in   system clock
//   rstn        in   asynchronous active-low reset
//   phase_align in   force phase 0 on the next cycle
//   phase       out  current slot phase (0..4)
//   pix_clk     out  divided pixel clock, aligned with phase
module slant_slot_wheel
  import slant_pkg::*;
(
  input  logic       Cclk,
  input  logic       rstn,
  input  logic       phase_align,
  output logic [2:0] phase,
  output logic       pix_clk
);

  logic [2:0] phase_nxt;

  always_comb begin
    phase_nxt = (phase == PH_LAST) ? PH_HDMI0 : phase + 3'd1;
    if (phase_align) begin
      phase_nxt = PH_HDMI0;
    end
  end

  // pix_clk is decoded from the next phase so the registered copy lines up
  // with the phase it describes rather than lagging by one cycle.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      phase   <= PH_HDMI0;
      pix_clk <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      pix_clk <= (phase_nxt == PH_HDMI0) || (phase_nxt == PH_HDMI1);
    end
  end

endmodule

// File: rtl/slant_rdport_arbiter.sv
// rtl/slant_rdport_arbiter.sv - time-slot arbiter for the slant Y/C memory read port
// Purpose: shares one memory read port between HDMI scan-out, radio TX and
//          debug readback on a 5-cycle slot wheel; lends idle slots by fixed
//          priority, issues registered reads and returns tagged data.
// Ports:
//   Cclk, rstn                 clock, asynchronous active-low reset
//   arb_en                     0 blocks new grants; in-flight reads still return
//   phase_align                restart the slot wheel at phase 0
//   <x>_req/_addr              request and address (x = hdmi, tx, dbg)
//   <x>_gnt                    combinational grant
//   <x>_rvalid/_rdata          1-cycle return pulse and held read data
//   mem_en/mem_addr/mem_rdata  memory read port
//   pix_clk, phase             divided pixel clock and slot phase
//   borrow_cnt                 saturating count of slots lent to a non-owner
module slant_rdport_arbiter
  import slant_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 40,
  parameter int BORROW_W = 16
) (
  input  logic                Cclk,
  input  logic                rstn,
  input  logic                arb_en,
  input  logic                phase_align,
  input  logic                hdmi_req,
  input  logic [ADDR_W-1:0]   hdmi_addr,
  output logic                hdmi_gnt,
  output logic                hdmi_rvalid,
  output logic [DATA_W-1:0]   hdmi_rdata,
  input  logic                tx_req,
  input  logic [ADDR_W-1:0]   tx_addr,
  output logic                tx_gnt,
  output logic                tx_rvalid,
  output logic [DATA_W-1:0]   tx_rdata,
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                pix_clk,
  output logic [2:0]          phase,
  output logic [BORROW_W-1:0] borrow_cnt
);

  tag_t              owner;
  tag_t              win;
  logic              owner_req;
  logic [ADDR_W-1:0] win_addr;
  logic              borrowed;
  tag_t              issue_tag;

  slant_slot_wheel u_wheel (
    .Cclk        (Cclk),
    .rstn        (rstn),
    .phase_align (phase_align),
    .phase       (phase),
    .pix_clk     (pix_clk)
  );

  // Grant selection: owner first, otherwise lend by HDMI > TX > DBG.
  // Ownership follows the current phase even when phase_align is pulsed,
  // since the wheel only restarts on the following cycle.
  always_comb begin
    owner     = slot_owner(phase);
    win       = TAG_NONE;
    owner_req = 1'b0;
    case (owner)
      TAG_HDMI: owner_req = hdmi_req;
      TAG_TX:   owner_req = tx_req;
      TAG_DBG:  owner_req = dbg_req;
      default:  owner_req = 1'b0;
    endcase
    if (arb_en) begin
      if (owner_req) begin
        win = owner;
      end else if (hdmi_req) begin
        win = TAG_HDMI;
      end else if (tx_req) begin
        win = TAG_TX;
      end else if (dbg_req) begin
        win = TAG_DBG;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    case (win)
      TAG_HDMI: win_addr = hdmi_addr;
      TAG_TX:   win_addr = tx_addr;
      TAG_DBG:  win_addr = dbg_addr;
      default:  win_addr = '0;
    endcase
  end

  assign hdmi_gnt = (win == TAG_HDMI);
  assign tx_gnt   = (win == TAG_TX);
  assign dbg_gnt  = (win == TAG_DBG);
  assign borrowed = (win != TAG_NONE) && (win != owner);

  // Issue stage: a grant is only raised with its req, so a grant is an accept.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      issue_tag  <= TAG_NONE;
      borrow_cnt <= '0;
    end else begin
      mem_en    <= (win != TAG_NONE);
      issue_tag <= win;
      if (win != TAG_NONE) begin
        mem_addr <= win_addr;
      end
      if (borrowed && (borrow_cnt != {BORROW_W{1'b1}})) begin
        borrow_cnt <= borrow_cnt + {{(BORROW_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Return stage: the memory data for the issued address is sampled at the
  // edge ending the mem_en cycle and routed by the tag that travelled with it.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      hdmi_rvalid <= 1'b0;
      tx_rvalid   <= 1'b0;
      dbg_rvalid  <= 1'b0;
      hdmi_rdata  <= '0;
      tx_rdata    <= '0;
      dbg_rdata   <= '0;
    end else begin
      hdmi_rvalid <= (issue_tag == TAG_HDMI);
      tx_rvalid   <= (issue_tag == TAG_TX);
      dbg_rvalid  <= (issue_tag == TAG_DBG);
      if (issue_tag == TAG_HDMI) begin
        hdmi_rdata <= mem_rdata;
      end
      if (issue_tag == TAG_TX) begin
        tx_rdata <= mem_rdata;
      end
      if (issue_tag == TAG_DBG) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule
